// File: rtl/except_pkg.sv
// except_pkg
// Shared definitions for the MEM-stage exception resolver:
//   - excepttype codes delivered to CP0
//   - CP0 register addresses that the WB forwarding path recognises
//   - bit positions of the raw exception flags coming from MEM
//   - resolver state encoding
package except_pkg;

    // Resolved exception codes presented to CP0
    localparam logic [31:0] EXC_NONE     = 32'h0000_0000;
    localparam logic [31:0] EXC_INT      = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL  = 32'h0000_0008;
    localparam logic [31:0] EXC_INV_INST = 32'h0000_000a;
    localparam logic [31:0] EXC_TRAP     = 32'h0000_000d;
    localparam logic [31:0] EXC_OVERFLOW = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET     = 32'h0000_000e;

    // CP0 register numbers seen on the WB write port
    localparam logic [4:0] CP0_REG_STATUS = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_REG_EPC    = 5'd14;

    // Cause bits that software may write (IP1..IP0 and IV/WP)
    localparam logic [31:0] CAUSE_WR_MASK = 32'h00C0_0300;

    // Raw flag bit positions
    localparam int RAW_SYSCALL  = 8;
    localparam int RAW_INV_INST = 9;
    localparam int RAW_TRAP     = 10;
    localparam int RAW_OVERFLOW = 11;
    localparam int RAW_ERET     = 12;

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_SHADOW = 1'b1
    } except_state_t;

endpackage

// File: rtl/except_unit_if.sv
// except_unit_if
// Bundles the MEM-stage, CP0 and WB-forwarding signals of the exception
// resolver. The pipeline side uses the master modport, except_unit the
// slave modport.
//   MEM:  valid_i, excepttype_raw_i, current_inst_address_i, is_in_delayslot_i
//   CP0:  cp0_status_i, cp0_cause_i, cp0_epc_i
//   WB:   wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i
//   out:  excepttype_o, is_in_delayslot_o, flush_o, new_pc_o, shadow_o,
//         exc_count_o
interface except_unit_if;
    logic        valid_i;
    logic [31:0] excepttype_raw_i;
    logic [31:0] current_inst_address_i;
    logic        is_in_delayslot_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic [31:0] excepttype_o;
    logic        is_in_delayslot_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        shadow_o;
    logic [31:0] exc_count_o;

    modport master (
        output valid_i, excepttype_raw_i, current_inst_address_i,
               is_in_delayslot_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
               wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
        input  excepttype_o, is_in_delayslot_o, flush_o, new_pc_o,
               shadow_o, exc_count_o
    );

    modport slave (
        input  valid_i, excepttype_raw_i, current_inst_address_i,
               is_in_delayslot_i, cp0_status_i, cp0_cause_i, cp0_epc_i,
               wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
        output excepttype_o, is_in_delayslot_o, flush_o, new_pc_o,
               shadow_o, exc_count_o
    );
endinterface

// File: rtl/except_unit_cp0_fwd.sv
// cp0_fwd
// Combinational WB-to-CP0 bypass. A CP0 write sitting in WB has not yet
// reached the register file, so its value replaces the registered one.
//   in:  status_i, cause_i, epc_i (registered CP0), wb_we_i, wb_waddr_i,
//        wb_data_i (pending WB write)
//   out: status_o, cause_o, epc_o (effective values)
module cp0_fwd
    import except_pkg::*;
(
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_waddr_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o
);

    always_comb begin
        status_o = status_i;
        cause_o  = cause_i;
        epc_o    = epc_i;
        if (wb_we_i) begin
            case (wb_waddr_i)
                CP0_REG_STATUS: status_o = wb_data_i;
                // Only the software-writable cause fields come from WB;
                // the hardware interrupt-pending bits stay live.
                CP0_REG_CAUSE:  cause_o  = (cause_i & ~CAUSE_WR_MASK) |
                                           (wb_data_i & CAUSE_WR_MASK);
                CP0_REG_EPC:    epc_o    = wb_data_i;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/except_unit.sv
// except_unit
// MEM-stage exception resolver. Picks one excepttype code for CP0, raises
// flush and the redirect PC, and holds off interrupts for SHADOW_CYCLES
// cycles after each taken non-eret exception.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : except_unit_if.slave (MEM flags, CP0 values, WB write, outputs)
// Parameters: EXC_VECTOR (redirect target), SHADOW_CYCLES (1..15).
// Optional: define EXCEPT_STATS_EN to enable the taken-exception counter on
// exc_count_o; otherwise exc_count_o is constant 0.
module except_unit
    import except_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
    parameter int          SHADOW_CYCLES = 4
)(
    input  logic          clk,
    input  logic          rst,
    except_unit_if.slave  bus
);

    localparam logic [3:0] SHADOW_RELOAD = 4'(SHADOW_CYCLES - 1);

    except_state_t state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          int_pend_q;
    logic          ds_q;
    logic [31:0]   status_f, cause_f, epc_f;
    logic          irq;
    logic          int_take;
    logic [31:0]   code;
    logic          flush;
    logic          unused_bits;

    cp0_fwd u_cp0_fwd (
        .status_i   (bus.cp0_status_i),
        .cause_i    (bus.cp0_cause_i),
        .epc_i      (bus.cp0_epc_i),
        .wb_we_i    (bus.wb_cp0_we_i),
        .wb_waddr_i (bus.wb_cp0_waddr_i),
        .wb_data_i  (bus.wb_cp0_data_i),
        .status_o   (status_f),
        .cause_o    (cause_f),
        .epc_o      (epc_f)
    );

    assign unused_bits = ^{bus.excepttype_raw_i[31:13], bus.excepttype_raw_i[7:0],
                           cause_f[31:16], cause_f[7:0],
                           status_f[31:16], status_f[7:2]};

    assign irq = ((cause_f[15:8] & status_f[15:8]) != 8'h00) &&
                 status_f[0] && !status_f[1];

    // Code selection. The interrupt outranks every synchronous flag because
    // the flush kills the instruction that raised them.
    always_comb begin
        int_take = int_pend_q && bus.valid_i &&
                   (bus.current_inst_address_i != 32'h0) &&
                   (state_q == ST_NORMAL);
        code = EXC_NONE;
        if (bus.valid_i) begin
            if (int_take)                                  code = EXC_INT;
            else if (bus.excepttype_raw_i[RAW_SYSCALL])    code = EXC_SYSCALL;
            else if (bus.excepttype_raw_i[RAW_INV_INST])   code = EXC_INV_INST;
            else if (bus.excepttype_raw_i[RAW_TRAP])       code = EXC_TRAP;
            else if (bus.excepttype_raw_i[RAW_OVERFLOW])   code = EXC_OVERFLOW;
            else if (bus.excepttype_raw_i[RAW_ERET])       code = EXC_ERET;
        end
        flush = (code != EXC_NONE);
    end

    assign bus.excepttype_o      = code;
    assign bus.flush_o           = flush;
    assign bus.new_pc_o          = (code == EXC_ERET) ? epc_f :
                                   (flush ? EXC_VECTOR : 32'h0);
    assign bus.shadow_o          = (state_q == ST_SHADOW);
    assign bus.is_in_delayslot_o = ds_q;

    // Shadow window sequencing: the counter is loaded with N-1 so that the
    // window spans exactly N cycles, leaving on the cycle it reads zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_NORMAL: begin
                if (flush && (code != EXC_ERET)) begin
                    state_d = ST_SHADOW;
                    cnt_d   = SHADOW_RELOAD;
                end
            end
            ST_SHADOW: begin
                if (flush) begin
                    cnt_d = SHADOW_RELOAD;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_NORMAL;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_NORMAL;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // The pending latch only holds while irq stays asserted, so a dropped
    // request never fires late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_NORMAL;
            cnt_q      <= 4'd0;
            int_pend_q <= 1'b0;
            ds_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!irq || int_take)
                int_pend_q <= 1'b0;
            else if (state_q == ST_NORMAL)
                int_pend_q <= 1'b1;
            if (flush)
                ds_q <= bus.is_in_delayslot_i;
        end
    end

`ifdef EXCEPT_STATS_EN
    logic [31:0] exc_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            exc_cnt_q <= 32'h0;
        else if (flush && (code != EXC_ERET))
            exc_cnt_q <= exc_cnt_q + 32'h1;
    end

    assign bus.exc_count_o = exc_cnt_q;
`else
    assign bus.exc_count_o = 32'h0;
`endif

endmodule
